pit_irq_monitor: RTL
====================

// Module: pit_irq_monitor
// PURPOSE
//   Receiving end of the timer interrupt line. Detects minipit "interrupting" pulses, latches
//   them as a pending interrupt, and holds that interrupt until the host acknowledges it.
//   Counts pulses that arrive before the acknowledge and timestamps the first one.
//   Measures the interval between consecutive pulses for host readback and timer verification.
// PARAMETERS
//   COUNT_WIDTH  8   width of saturating pulse counter irq_count
//   TS_WIDTH     16  width of free-running timestamp, first_ts and last_period
// PORTS
//   clk           input   1            system clock
//   rst_n         input   1            synchronous reset, active low
//   irq_in        input   1            interrupt line from timer (nominally 1-cycle pulses)
//   enable        input   1            1 = capture edges; 0 = ignore new edges
//   ack           input   1            host acknowledge, sampled per cycle
//   pending       output  1            interrupt latched, awaiting ack
//   irq_count     output  COUNT_WIDTH  edges captured since last ack (saturating)
//   overflow      output  1            >=1 edge arrived while already pending (sticky until ack)
//   first_ts      output  TS_WIDTH     timestamp of first edge since last ack
//   last_period   output  TS_WIDTH     cycles between two most recent captured edges
//   period_valid  output  1            last_period holds a real measurement
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): all outputs 0; ts counter, irq_d, last_edge_ts, seen_edge cleared.
//     Reset mid-PENDING discards everything, including overflow and period history.
//   ts: free-running TS_WIDTH counter, +1 every cycle, wraps mod 2^TS_WIDTH.
//   Edge: edge = enable & irq_in & ~irq_d. irq_d <= irq_in every cycle, regardless of enable.
//     A line held high for N cycles is one edge. Edges are not detected while enable=0.
//     The same-cycle ts value is the edge timestamp.
//   Latency: edge in cycle T -> outputs updated and visible in cycle T+1.
//   FSM (pending = state==PENDING):
//     IDLE    + edge        -> PENDING; irq_count<=1; first_ts<=ts; overflow<=0
//     IDLE    + ack         -> IDLE (ack ignored, no side effects)
//     PENDING + edge, !ack  -> PENDING; irq_count<=sat(irq_count+1); overflow<=1
//     PENDING + ack, !edge  -> IDLE; irq_count<=0; overflow<=0; first_ts<=0
//     PENDING + ack + edge  -> PENDING; ack clears, then the edge is a new first edge:
//                              irq_count<=1; first_ts<=ts; overflow<=0
//     No edge and no ack    -> all state held.
//   Saturation: irq_count stops at 2^COUNT_WIDTH-1; no wrap; overflow is still set.
//   Period: on every edge, whether or not pending:
//     if seen_edge then last_period <= ts - last_edge_ts (mod 2^TS_WIDTH) and period_valid <= 1.
//     last_edge_ts <= ts; seen_edge <= 1.
//     ack does not clear last_period or period_valid; only reset does.
//   Interval across ts wrap: a result mod 2^TS_WIDTH is correct when the true interval is < 2^TS_WIDTH.
//   enable low: FSM still honours ack; pending and period state held.
// TESTING
//   1 Reset; irq_in pulse at ts=5 -> at ts=6: pending=1, irq_count=1, first_ts=5, overflow=0,
//     period_valid=0.
//   2 Pulses at ts=5 and ts=15, no ack -> irq_count=2, overflow=1, first_ts=5,
//     last_period=10, period_valid=1.
//   3 Pending state; ack and a new edge in the same cycle at ts=40 -> next cycle: pending=1,
//     irq_count=1, first_ts=40, overflow=0.
//   4 COUNT_WIDTH=2; 6 pulses without ack -> irq_count=3 (held), overflow=1; ack -> pending=0,
//     irq_count=0.
//   5 irq_in held high 4 cycles -> irq_count=1. irq_in pulse with enable=0 -> no change.
//     ack while IDLE -> no change.
//   6 TS_WIDTH=4; edges at ts=14 and ts=3 (after wrap) -> last_period=5.
//     Then rst_n=0 while pending -> all outputs 0.

Source files
------------

// File: rtl/pit_irq_monitor_if.sv
// Timer-interrupt monitor bus: interrupt line, enable and host ack in; status and timing readback out.
interface pit_irq_monitor_if #(
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned TS_WIDTH    = 16
);
  logic                   irq_in;
  logic                   enable;
  logic                   ack;
  logic                   pending;
  logic [COUNT_WIDTH-1:0] irq_count;
  logic                   overflow;
  logic [TS_WIDTH-1:0]    first_ts;
  logic [TS_WIDTH-1:0]    last_period;
  logic                   period_valid;

  modport master (
    output irq_in, enable, ack,
    input  pending, irq_count, overflow, first_ts, last_period, period_valid
  );

  modport slave (
    input  irq_in, enable, ack,
    output pending, irq_count, overflow, first_ts, last_period, period_valid
  );
endinterface

// File: rtl/pit_irq_monitor.sv
// Latches timer interrupt pulses as a pending interrupt held until host ack, counting and
// timestamping them, and measures the interval between consecutive captured edges.
module pit_irq_monitor #(
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned TS_WIDTH    = 16
) (
  input logic              clk,
  input logic              rst_n,
  pit_irq_monitor_if.slave bus
);
  typedef enum logic {IDLE, PENDING} state_t;

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  state_t                 state;
  logic [TS_WIDTH-1:0]    ts;
  logic [TS_WIDTH-1:0]    last_edge_ts;
  logic                   irq_d;
  logic                   seen_edge;
  logic                   edge_det;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   overflow_q;
  logic [TS_WIDTH-1:0]    first_ts_q;
  logic [TS_WIDTH-1:0]    last_period_q;
  logic                   period_valid_q;

  always_comb edge_det = bus.enable & bus.irq_in & ~irq_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      ts             <= '0;
      last_edge_ts   <= '0;
      irq_d          <= 1'b0;
      seen_edge      <= 1'b0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
      first_ts_q     <= '0;
      last_period_q  <= '0;
      period_valid_q <= 1'b0;
    end else begin
      ts    <= ts + TS_WIDTH'(1);
      irq_d <= bus.irq_in;

      // Interval tracking runs on every captured edge, independent of the pending state.
      if (edge_det) begin
        if (seen_edge) begin
          last_period_q  <= ts - last_edge_ts;
          period_valid_q <= 1'b1;
        end
        last_edge_ts <= ts;
        seen_edge    <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (edge_det) begin
            state      <= PENDING;
            count_q    <= COUNT_ONE;
            first_ts_q <= ts;
            overflow_q <= 1'b0;
          end
        end
        PENDING: begin
          // Ack with a simultaneous edge: the ack retires the old interrupt and the
          // edge opens a fresh one, so the state stays PENDING with a restarted count.
          if (edge_det && bus.ack) begin
            count_q    <= COUNT_ONE;
            first_ts_q <= ts;
            overflow_q <= 1'b0;
          end else if (edge_det) begin
            if (count_q != COUNT_MAX) count_q <= count_q + COUNT_WIDTH'(1);
            overflow_q <= 1'b1;
          end else if (bus.ack) begin
            state      <= IDLE;
            count_q    <= '0;
            overflow_q <= 1'b0;
            first_ts_q <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pending      = (state == PENDING);
  assign bus.irq_count    = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.first_ts     = first_ts_q;
  assign bus.last_period  = last_period_q;
  assign bus.period_valid = period_valid_q;
endmodule
